// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler
//   Round-robin scheduler in front of a 1-to-4 demultiplexer. Words arrive on a
//   valid/ready stream. Each word is held in a one-entry register. It is
//   committed to the next enabled channel in round-robin order and presented
//   until that channel's consumer takes it. A new word can be loaded in the
//   same cycle a held word is delivered, which sustains one word per cycle.
//
// Parameters
//   DATA_W    width of the data word
//   CNT_W     width of the delivered-word counter
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   upstream word valid
//   in_ready   out  scheduler can accept a word this cycle
//   in_data    in   upstream word [DATA_W]
//   chan_en    in   per-channel enable mask [4]
//   sel        out  demux select = channel index of the held word [2]
//   out_data   out  held word, common to all channels [DATA_W]
//   out_valid  out  one-hot valid, bit sel while a word is held [4]
//   out_ready  in   per-channel consumer ready [4]
//   word_cnt   out  words delivered since reset, wrapping [CNT_W]
module demux_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        chan_en,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic any_en;
  logic deliver;
  logic accept;

  // First enabled channel at or after p, searching upward modulo 4. The
  // loop runs from the farthest candidate down so the nearest one wins.
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] en);
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (en[idx]) pick = idx;
    end
  endfunction

  assign any_en  = |chan_en;
  assign deliver = (state_q == HOLD) && out_ready[sel_q];

  // A held word only makes room for a new one when it is being delivered,
  // and nothing is accepted while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) in_ready = any_en;
      else                 in_ready = out_ready[sel_q] && any_en;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          sel_d   = pick(ptr_q, chan_en);
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The destination was committed at load time; chan_en changes
        // here never reroute the held word.
        if (deliver) begin
          cnt_d = cnt_q + CNT_W'(1);
          ptr_d = sel_q + 2'd1;
          if (accept) begin
            data_d = in_data;
            sel_d  = pick(sel_q + 2'd1, chan_en);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = data_q;
  assign out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
  assign word_cnt  = cnt_q;

endmodule
